sys_ctrl_param: RTL and testbench
=================================

# sys_ctrl_param

Parametrised command controller between the UART RX/TX, the register file, the ALU and the TX FIFO. Decodes framed commands (write register, read register, ALU with operands, ALU without operands) from the RX byte stream, drives the register file and ALU, and serialises multi-byte results into the TX FIFO LSB-first. Relative to the previous controller it adds a configurable ALU result width, an error-response byte for unknown commands, a per-byte inactivity timeout, and fully registered outputs.

## Interface
Parameters:
- FRAME_W, 8, RX/TX byte width
- ALU_W, 16, ALU result width; must be a multiple of FRAME_W (NBYTES = ALU_W/FRAME_W)
- FUN_W, 4, ALU function code width
- ADDR_W, 4, register file address width
- CMD_WR / CMD_RD / CMD_ALU_OP / CMD_ALU_NOP, 8'hAA / 8'hBB / 8'hCC / 8'hDD, command codes
- ERR_CODE, 8'hEE, byte pushed on error
- TIMEOUT, 255, max idle cycles between frame bytes (also used for Rd_Data_Valid / OUT_VALID waits)
- OPA_ADDR / OPB_ADDR, 0 / 1, operand register addresses

Ports (single clock; reset is asynchronous and active-high):
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- RX_P_DATA  in  FRAME_W  received byte
- RX_D_VLD  in  1  one-cycle byte-valid strobe
- Rd_Data  in  FRAME_W  register file read data
- Rd_Data_Valid  in  1  read data valid
- ALU_OUT  in  ALU_W  ALU result
- OUT_VALID  in  1  ALU result valid
- FIFO_FULL  in  1  TX FIFO full
- WrEn, RdEn  out  1  register file strobes
- address  out  ADDR_W  register file address
- WrData  out  FRAME_W  register file write data
- ALU_EN  out  1  ALU start pulse
- ALU_FUN  out  FUN_W  ALU function
- CLK_EN  out  1  ALU clock-gate enable
- clk_div_en  out  1  clock divider enable (constant 1 out of reset)
- TX_P_DATA  out  FRAME_W  byte to TX FIFO
- TX_D_VLD  out  1  TX FIFO push strobe
- busy  out  1  high whenever state is not IDLE
- err  out  1  one-cycle pulse coinciding with an ERR_CODE push

## Operation
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX_PUSH.
- IDLE + RX_D_VLD: CMD_WR→WR_ADDR; CMD_RD→RD_ADDR; CMD_ALU_OP→OP_A; CMD_ALU_NOP→FUN; any other byte→TX_PUSH with ERR_CODE (1 byte).
- WR_ADDR: latch RX_P_DATA[ADDR_W-1:0]. WR_DATA: WrEn=1 for 1 cycle with address/WrData, →IDLE.
- RD_ADDR: RdEn pulse with address, →RD_WAIT; Rd_Data_Valid captures Rd_Data into TX buffer (1 byte) →TX_PUSH.
- OP_A / OP_B: WrEn pulse to OPA_ADDR / OPB_ADDR with byte. FUN: ALU_FUN=RX_P_DATA[FUN_W-1:0], ALU_EN 1-cycle pulse, →ALU_WAIT; OUT_VALID captures ALU_OUT, loads NBYTES bytes →TX_PUSH.
- CLK_EN high from entry to OP_A/FUN until OUT_VALID is captured; otherwise 0.
- TX_PUSH: push one byte per cycle when !FIFO_FULL (TX_D_VLD=1, TX_P_DATA=byte k, k=0 is LSB); stall while FIFO_FULL; →IDLE after last byte.
- Timeout: counter clears on state entry and on each accepted byte; reaching TIMEOUT in any waiting state (WR_*, RD_*, OP_*, FUN, ALU_WAIT) → ERR_CODE push, →IDLE. No timeout in TX_PUSH.
- RX_D_VLD in RD_WAIT, ALU_WAIT or TX_PUSH: byte dropped.

## Timing
- Reset: all outputs 0 except clk_div_en=1 and TX_P_DATA=0; state IDLE; counters and buffers cleared. RST mid-operation aborts immediately; no pending push survives.
- All outputs are registered: strobes appear the cycle after the triggering input edge.
- WR: WrEn asserted 1 cycle after the data byte's RX_D_VLD cycle.
- ALU: first TX_D_VLD is 1 cycle after OUT_VALID is captured; NBYTES consecutive pushes when the FIFO is not full.
- Unknown command: TX_D_VLD and err both high for 1 cycle, 1 cycle after the byte is received (when the FIFO is not full).

## Structure
- Package sys_ctrl_pkg: state encoding, default command codes, ERR_CODE.
- Sub-module sys_ctrl_tx_ser: NBYTES-deep byte buffer with load/pop/FIFO_FULL handshake and last-byte flag.

## Test plan
- AA,05,3C → WrEn one cycle, address=5, WrData=3C; busy drops next cycle.
- BB,03; Rd_Data=5A with valid 2 cycles later → single push 5A.
- CC,07,02,00; ALU_OUT=0x0102 → writes 07@0, 02@1, ALU_FUN=0, pushes 02 then 01.
- ALU_W=32, DD,01; ALU_OUT=0xA1B2C3D4 with FIFO_FULL high 3 cycles mid-stream → D4,C3,B2,A1 in order, no loss or duplicate.
- Byte 0x42 in IDLE → push EE with err pulse; AA then silence for TIMEOUT cycles → EE, IDLE.
- RST asserted during ALU_WAIT → all outputs at reset values immediately; next AA frame completes normally.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl shared definitions: controller state encoding,
// default command codes and the error-response byte.
package sys_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_WAIT,
      OP_A,
      OP_B,
      FUN,
      ALU_WAIT,
      TX_PUSH
   } state_t;

   localparam logic [7:0] CMD_WR_DEF      = 8'hAA;
   localparam logic [7:0] CMD_RD_DEF      = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP_DEF  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP_DEF = 8'hDD;
   localparam logic [7:0] ERR_CODE_DEF    = 8'hEE;

endpackage

// File: rtl/sys_ctrl_tx_ser.sv
// Result serialiser: holds up to NBYTES bytes and pushes them
// LSB-first into the TX FIFO, one per cycle while not full.
// Ports: clk/rst; load, load_data, load_len, load_err (new
// result); full (FIFO full); tx_data/tx_vld/err (registered
// push); last (the final buffered byte goes out this edge).
module sys_ctrl_tx_ser #(
   parameter int FRAME_W = 8,
   parameter int ALU_W   = 16,
   localparam int NBYTES = ALU_W / FRAME_W,
   localparam int CNT_W  = $clog2(NBYTES + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [ALU_W-1:0]   load_data,
   input  logic [CNT_W-1:0]   load_len,
   input  logic               load_err,
   input  logic               full,
   output logic [FRAME_W-1:0] tx_data,
   output logic               tx_vld,
   output logic               err,
   output logic               last
);

   logic [ALU_W-1:0] buf_q;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   assign last = (cnt_q == CNT_W'(1)) && !full;

   // A load pushes its first byte on the same edge when the FIFO
   // has room, so single-byte responses leave one cycle after
   // the triggering input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         tx_data <= '0;
         tx_vld  <= 1'b0;
         err     <= 1'b0;
      end else begin
         tx_vld <= 1'b0;
         err    <= 1'b0;
         if (load) begin
            err_q <= load_err;
            if (!full) begin
               tx_data <= load_data[FRAME_W-1:0];
               tx_vld  <= 1'b1;
               err     <= load_err;
               buf_q   <= load_data >> FRAME_W;
               cnt_q   <= load_len - CNT_W'(1);
            end else begin
               buf_q <= load_data;
               cnt_q <= load_len;
            end
         end else if (cnt_q != '0 && !full) begin
            tx_data <= buf_q[FRAME_W-1:0];
            tx_vld  <= 1'b1;
            err     <= err_q;
            buf_q   <= buf_q >> FRAME_W;
            cnt_q   <= cnt_q - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/sys_ctrl_param.sv
// Command controller: decodes RX frames, drives register file
// and ALU, returns results/errors to the TX FIFO.
// Ports: CLK/RST; RX_P_DATA/RX_D_VLD in; Rd_Data(_Valid),
// ALU_OUT/OUT_VALID, FIFO_FULL in; WrEn/RdEn/address/WrData,
// ALU_EN/ALU_FUN/CLK_EN/clk_div_en, TX_P_DATA/TX_D_VLD,
// busy/err out (all registered).
module sys_ctrl_param
   import sys_ctrl_pkg::*;
#(
   parameter int FRAME_W = 8,
   parameter int ALU_W   = 16,
   parameter int FUN_W   = 4,
   parameter int ADDR_W  = 4,
   parameter logic [FRAME_W-1:0] CMD_WR      = CMD_WR_DEF,
   parameter logic [FRAME_W-1:0] CMD_RD      = CMD_RD_DEF,
   parameter logic [FRAME_W-1:0] CMD_ALU_OP  = CMD_ALU_OP_DEF,
   parameter logic [FRAME_W-1:0] CMD_ALU_NOP = CMD_ALU_NOP_DEF,
   parameter logic [FRAME_W-1:0] ERR_CODE    = ERR_CODE_DEF,
   parameter int TIMEOUT = 255,
   parameter logic [ADDR_W-1:0] OPA_ADDR = ADDR_W'(0),
   parameter logic [ADDR_W-1:0] OPB_ADDR = ADDR_W'(1)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [FRAME_W-1:0] RX_P_DATA,
   input  logic               RX_D_VLD,
   input  logic [FRAME_W-1:0] Rd_Data,
   input  logic               Rd_Data_Valid,
   input  logic [ALU_W-1:0]   ALU_OUT,
   input  logic               OUT_VALID,
   input  logic               FIFO_FULL,
   output logic               WrEn,
   output logic               RdEn,
   output logic [ADDR_W-1:0]  address,
   output logic [FRAME_W-1:0] WrData,
   output logic               ALU_EN,
   output logic [FUN_W-1:0]   ALU_FUN,
   output logic               CLK_EN,
   output logic               clk_div_en,
   output logic [FRAME_W-1:0] TX_P_DATA,
   output logic               TX_D_VLD,
   output logic               busy,
   output logic               err
);

   localparam int NBYTES = ALU_W / FRAME_W;
   localparam int CNT_W  = $clog2(NBYTES + 1);
   localparam int TM_W   = $clog2(TIMEOUT + 1);

   state_t state, nstate;
   logic [TM_W-1:0]    tcnt, tcnt_n;
   logic [ADDR_W-1:0]  alat, alat_n;
   logic [ADDR_W-1:0]  addr_n;
   logic [FRAME_W-1:0] wdata_n;
   logic [FUN_W-1:0]   fun_n;
   logic               wr_n, rd_n, alu_en_n;
   logic               waiting, ev, tmo;
   logic               ld, ld_err, ser_last;
   logic [ALU_W-1:0]   ld_data;
   logic [CNT_W-1:0]   ld_len;
   state_t             push_st;

   assign waiting = state inside {WR_ADDR, WR_DATA, RD_ADDR,
                                  RD_WAIT, OP_A, OP_B, FUN,
                                  ALU_WAIT};

   always_comb begin
      ev = RX_D_VLD;
      if (state == RD_WAIT)  ev = Rd_Data_Valid;
      if (state == ALU_WAIT) ev = OUT_VALID;
   end

   assign tmo = waiting && !ev && (tcnt == TM_W'(TIMEOUT - 1));

   // A 1-byte load that goes out immediately needs no TX_PUSH.
   assign push_st = FIFO_FULL ? TX_PUSH : IDLE;

   always_comb begin
      nstate   = state;
      alat_n   = alat;
      addr_n   = address;
      wdata_n  = WrData;
      fun_n    = ALU_FUN;
      wr_n     = 1'b0;
      rd_n     = 1'b0;
      alu_en_n = 1'b0;
      ld       = 1'b0;
      ld_data  = '0;
      ld_len   = CNT_W'(1);
      ld_err   = 1'b0;
      unique case (state)
         IDLE: begin
            if (RX_D_VLD) begin
               unique case (1'b1)
                  (RX_P_DATA == CMD_WR):      nstate = WR_ADDR;
                  (RX_P_DATA == CMD_RD):      nstate = RD_ADDR;
                  (RX_P_DATA == CMD_ALU_OP):  nstate = OP_A;
                  (RX_P_DATA == CMD_ALU_NOP): nstate = FUN;
                  default: begin
                     ld      = 1'b1;
                     ld_data = ALU_W'(ERR_CODE);
                     ld_err  = 1'b1;
                     nstate  = push_st;
                  end
               endcase
            end
         end
         WR_ADDR: if (ev) begin
            alat_n = RX_P_DATA[ADDR_W-1:0];
            nstate = WR_DATA;
         end
         WR_DATA: if (ev) begin
            wr_n    = 1'b1;
            addr_n  = alat;
            wdata_n = RX_P_DATA;
            nstate  = IDLE;
         end
         RD_ADDR: if (ev) begin
            rd_n   = 1'b1;
            addr_n = RX_P_DATA[ADDR_W-1:0];
            nstate = RD_WAIT;
         end
         RD_WAIT: if (ev) begin
            ld      = 1'b1;
            ld_data = ALU_W'(Rd_Data);
            nstate  = push_st;
         end
         OP_A: if (ev) begin
            wr_n    = 1'b1;
            addr_n  = OPA_ADDR;
            wdata_n = RX_P_DATA;
            nstate  = OP_B;
         end
         OP_B: if (ev) begin
            wr_n    = 1'b1;
            addr_n  = OPB_ADDR;
            wdata_n = RX_P_DATA;
            nstate  = FUN;
         end
         FUN: if (ev) begin
            fun_n    = RX_P_DATA[FUN_W-1:0];
            alu_en_n = 1'b1;
            nstate   = ALU_WAIT;
         end
         ALU_WAIT: if (ev) begin
            ld      = 1'b1;
            ld_data = ALU_OUT;
            ld_len  = CNT_W'(NBYTES);
            nstate  = (NBYTES == 1) ? push_st : TX_PUSH;
         end
         TX_PUSH: if (ser_last) nstate = IDLE;
         default: nstate = IDLE;
      endcase
      if (tmo) begin
         ld      = 1'b1;
         ld_data = ALU_W'(ERR_CODE);
         ld_len  = CNT_W'(1);
         ld_err  = 1'b1;
         nstate  = push_st;
      end
   end

   // Every accepted event moves the FSM, so a state change is
   // enough to restart the idle timer.
   always_comb begin
      tcnt_n = '0;
      if (waiting && nstate == state) tcnt_n = tcnt + TM_W'(1);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         tcnt       <= '0;
         alat       <= '0;
         WrEn       <= 1'b0;
         RdEn       <= 1'b0;
         address    <= '0;
         WrData     <= '0;
         ALU_EN     <= 1'b0;
         ALU_FUN    <= '0;
         CLK_EN     <= 1'b0;
         clk_div_en <= 1'b1;
         busy       <= 1'b0;
      end else begin
         state      <= nstate;
         tcnt       <= tcnt_n;
         alat       <= alat_n;
         WrEn       <= wr_n;
         RdEn       <= rd_n;
         address    <= addr_n;
         WrData     <= wdata_n;
         ALU_EN     <= alu_en_n;
         ALU_FUN    <= fun_n;
         CLK_EN     <= nstate inside {OP_A, OP_B, FUN, ALU_WAIT};
         clk_div_en <= 1'b1;
         busy       <= (nstate != IDLE);
      end
   end

   sys_ctrl_tx_ser #(
      .FRAME_W (FRAME_W),
      .ALU_W   (ALU_W)
   ) u_ser (
      .clk       (CLK),
      .rst       (RST),
      .load      (ld),
      .load_data (ld_data),
      .load_len  (ld_len),
      .load_err  (ld_err),
      .full      (FIFO_FULL),
      .tx_data   (TX_P_DATA),
      .tx_vld    (TX_D_VLD),
      .err       (err),
      .last      (ser_last)
   );

endmodule

// File: tb/tb_sys_ctrl_param.sv
// Scoreboard bench for sys_ctrl_param (ALU_W=32): expected TX
// bytes and register writes are queued, then checked on output.
module tb_sys_ctrl_param;

   localparam int FW  = 8;
   localparam int AW  = 32;
   localparam int TMO = 255;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [FW-1:0] RX_P_DATA = '0;
   logic          RX_D_VLD = 1'b0;
   logic [FW-1:0] Rd_Data = '0;
   logic          Rd_Data_Valid = 1'b0;
   logic [AW-1:0] ALU_OUT = '0;
   logic          OUT_VALID = 1'b0;
   logic          FIFO_FULL = 1'b0;
   logic          WrEn, RdEn, ALU_EN, CLK_EN, clk_div_en;
   logic [3:0]    address, ALU_FUN;
   logic [FW-1:0] WrData, TX_P_DATA;
   logic          TX_D_VLD, busy, err;

   sys_ctrl_param #(
      .FRAME_W (FW),
      .ALU_W   (AW),
      .TIMEOUT (TMO)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .RX_P_DATA     (RX_P_DATA),
      .RX_D_VLD      (RX_D_VLD),
      .Rd_Data       (Rd_Data),
      .Rd_Data_Valid (Rd_Data_Valid),
      .ALU_OUT       (ALU_OUT),
      .OUT_VALID     (OUT_VALID),
      .FIFO_FULL     (FIFO_FULL),
      .WrEn          (WrEn),
      .RdEn          (RdEn),
      .address       (address),
      .WrData        (WrData),
      .ALU_EN        (ALU_EN),
      .ALU_FUN       (ALU_FUN),
      .CLK_EN        (CLK_EN),
      .clk_div_en    (clk_div_en),
      .TX_P_DATA     (TX_P_DATA),
      .TX_D_VLD      (TX_D_VLD),
      .busy          (busy),
      .err           (err)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] d;
      logic       e;
   } tx_t;

   tx_t         tx_q[$];
   logic [11:0] wr_q[$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic exp_tx(input logic [7:0] d, input logic e);
      tx_t t;
      t.d = d;
      t.e = e;
      tx_q.push_back(t);
   endtask

   tx_t         mt;
   logic [11:0] mw;

   always @(negedge CLK) begin
      if (!RST) begin
         if (TX_D_VLD) begin
            chk("tx_expected", 64'(tx_q.size() != 0), 1);
            if (tx_q.size() != 0) begin
               mt = tx_q.pop_front();
               chk("tx_data", 64'(TX_P_DATA), 64'(mt.d));
               chk("tx_err", 64'(err), 64'(mt.e));
            end
         end else if (err) begin
            chk("err_with_push", 64'(TX_D_VLD), 1);
         end
         if (WrEn) begin
            chk("wr_expected", 64'(wr_q.size() != 0), 1);
            if (wr_q.size() != 0) begin
               mw = wr_q.pop_front();
               chk("wr_addr_data", 64'({address, WrData}),
                   64'(mw));
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      @(negedge CLK);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(negedge CLK);
      RX_D_VLD  = 1'b0;
   endtask

   task automatic alu_res(input logic [AW-1:0] d);
      @(negedge CLK);
      ALU_OUT   = d;
      OUT_VALID = 1'b1;
      @(negedge CLK);
      OUT_VALID = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (!busy && tx_q.size() == 0 && wr_q.size() == 0)
            break;
         @(negedge CLK);
      end
      chk({tag, "_done"},
          64'(!busy && tx_q.size() == 0 && wr_q.size() == 0), 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_wren"}, 64'(WrEn), 0);
      chk({tag, "_rden"}, 64'(RdEn), 0);
      chk({tag, "_addr"}, 64'(address), 0);
      chk({tag, "_wdata"}, 64'(WrData), 0);
      chk({tag, "_aluen"}, 64'(ALU_EN), 0);
      chk({tag, "_fun"}, 64'(ALU_FUN), 0);
      chk({tag, "_clken"}, 64'(CLK_EN), 0);
      chk({tag, "_divden"}, 64'(clk_div_en), 1);
      chk({tag, "_txd"}, 64'(TX_P_DATA), 0);
      chk({tag, "_txv"}, 64'(TX_D_VLD), 0);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_err"}, 64'(err), 0);
   endtask

   int n;

   initial begin
      repeat (3) @(negedge CLK);
      chk_reset("rst");
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      // register write
      wr_q.push_back({4'h5, 8'h3C});
      send(8'hAA);
      chk("wr_busy", 64'(busy), 1);
      send(8'h05);
      chk("wr_no_early", 64'(WrEn), 0);
      send(8'h3C);
      chk("wr_strobe", 64'(WrEn), 1);
      @(negedge CLK);
      chk("wr_busy_drop", 64'(busy), 0);
      chk("wr_one_cycle", 64'(WrEn), 0);
      wait_done("wr");

      // register read
      send(8'hBB);
      send(8'h03);
      chk("rd_strobe", 64'(RdEn), 1);
      chk("rd_addr", 64'(address), 3);
      exp_tx(8'h5A, 1'b0);
      @(negedge CLK);
      Rd_Data       = 8'h5A;
      Rd_Data_Valid = 1'b1;
      @(negedge CLK);
      Rd_Data_Valid = 1'b0;
      chk("rd_push_t", 64'(TX_D_VLD), 1);
      wait_done("rd");

      // ALU with operands
      wr_q.push_back({4'h0, 8'h07});
      wr_q.push_back({4'h1, 8'h02});
      send(8'hCC);
      chk("op_clken", 64'(CLK_EN), 1);
      send(8'h07);
      send(8'h02);
      send(8'h00);
      chk("op_aluen", 64'(ALU_EN), 1);
      chk("op_fun", 64'(ALU_FUN), 0);
      @(negedge CLK);
      chk("op_aluen_pulse", 64'(ALU_EN), 0);
      exp_tx(8'h02, 1'b0);
      exp_tx(8'h01, 1'b0);
      exp_tx(8'h00, 1'b0);
      exp_tx(8'h00, 1'b0);
      alu_res(32'h0000_0102);
      chk("op_first_push", 64'(TX_D_VLD), 1);
      chk("op_clken_off", 64'(CLK_EN), 0);
      wait_done("op");

      // ALU without operands, FIFO stall mid-stream
      send(8'hDD);
      chk("nop_clken", 64'(CLK_EN), 1);
      send(8'h01);
      chk("nop_aluen", 64'(ALU_EN), 1);
      chk("nop_fun", 64'(ALU_FUN), 1);
      exp_tx(8'hD4, 1'b0);
      exp_tx(8'hC3, 1'b0);
      exp_tx(8'hB2, 1'b0);
      exp_tx(8'hA1, 1'b0);
      alu_res(32'hA1B2_C3D4);
      chk("nop_first_push", 64'(TX_D_VLD), 1);
      FIFO_FULL = 1'b1;
      repeat (3) @(negedge CLK);
      FIFO_FULL = 1'b0;
      chk("nop_stall_left", 64'(tx_q.size()), 3);
      wait_done("nop");

      // unknown command
      exp_tx(8'hEE, 1'b1);
      send(8'h42);
      chk("unk_push_t", 64'(TX_D_VLD), 1);
      chk("unk_err_t", 64'(err), 1);
      @(negedge CLK);
      chk("unk_err_pulse", 64'(err), 0);
      wait_done("unk");

      // inactivity timeout
      exp_tx(8'hEE, 1'b1);
      send(8'hAA);
      n = 0;
      while (!TX_D_VLD && n < TMO + 20) begin
         @(negedge CLK);
         n++;
      end
      chk("tmo_latency", 64'(n >= TMO - 2 && n <= TMO + 2), 1);
      chk("tmo_err", 64'(err), 1);
      @(negedge CLK);
      chk("tmo_idle", 64'(busy), 0);
      wait_done("tmo");

      // reset in ALU_WAIT
      wr_q.push_back({4'h0, 8'h11});
      wr_q.push_back({4'h1, 8'h22});
      send(8'hCC);
      send(8'h11);
      send(8'h22);
      send(8'h03);
      @(negedge CLK);
      chk("ar_busy", 64'(busy), 1);
      chk("ar_clken", 64'(CLK_EN), 1);
      RST = 1'b1;
      #1;
      chk_reset("arst");
      @(negedge CLK);
      ALU_OUT   = 32'hDEAD_BEEF;
      OUT_VALID = 1'b1;
      @(negedge CLK);
      OUT_VALID = 1'b0;
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      chk("ar_no_push", 64'(TX_D_VLD), 0);
      wr_q.push_back({4'h9, 8'h77});
      send(8'hAA);
      send(8'h09);
      send(8'h77);
      chk("ar_wr_strobe", 64'(WrEn), 1);
      wait_done("ar");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
